// File: rtl/mat_mult_engine_if.sv
// Start/busy/done handshake and matrix buses for mat_mult_engine.
// Each 4x4 matrix is packed with element (r,c) at bits [(4r+c)*WIDTH +: WIDTH].
interface mat_mult_engine_if #(
  parameter int unsigned WIDTH = 32
);
  logic                  start;
  logic [16*WIDTH-1:0]   a;
  logic [16*WIDTH-1:0]   b;
  logic [16*WIDTH-1:0]   c;
  logic                  busy;
  logic                  done;

  modport master (
    output start, a, b,
    input  c, busy, done
  );

  modport slave (
    input  start, a, b,
    output c, busy, done
  );
endinterface

// File: rtl/mat_mult_engine.sv
// Fixed-point 4x4 matrix multiplier C = A x B, one output element per cycle.
// Define MAT_MULT_SATURATE_EN to saturate results instead of wrapping them.
module mat_mult_engine #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned FRAC_BITS = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  mat_mult_engine_if.slave bus
);
  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned SW = 2 * WIDTH + 2;

  typedef enum logic [1:0] {StIdle, StCompute, StDrain, StDone} state_e;

  state_e                 state_q;
  logic [3:0]             k_q;
  logic [15:0][WIDTH-1:0] a_q;
  logic [15:0][WIDTH-1:0] b_q;
  logic [15:0][WIDTH-1:0] c_q;
  logic signed [PW-1:0]   prod_q [4];
  logic signed [PW-1:0]   prod_d [4];
  logic                   s1_valid_q;
  logic [3:0]             s1_idx_q;
  logic                   busy_q;
  logic                   done_q;
  logic signed [SW-1:0]   sum;
  logic signed [SW-1:0]   shifted;
  logic [WIDTH-1:0]       res;
  logic                   unused_shift_hi;

  // Row i = k[3:2] of A against column j = k[1:0] of B.
  always_comb begin
    for (int m = 0; m < 4; m++) begin
      prod_d[m] = PW'($signed(a_q[{k_q[3:2], 2'(m)}])) *
                  PW'($signed(b_q[{2'(m), k_q[1:0]}]));
    end
  end

  always_comb begin
    sum     = SW'(prod_q[0]) + SW'(prod_q[1]) + SW'(prod_q[2]) + SW'(prod_q[3]);
    shifted = sum >>> FRAC_BITS;
`ifdef MAT_MULT_SATURATE_EN
    // In range when every bit from the WIDTH-bit sign position upward agrees.
    if ((&shifted[SW-1:WIDTH-1]) || !(|shifted[SW-1:WIDTH-1])) begin
      res = shifted[WIDTH-1:0];
    end else if (shifted[SW-1]) begin
      res = {1'b1, {(WIDTH-1){1'b0}}};
    end else begin
      res = {1'b0, {(WIDTH-1){1'b1}}};
    end
`else
    res = shifted[WIDTH-1:0];
`endif
  end

  assign unused_shift_hi = ^shifted[SW-1:WIDTH];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      k_q        <= '0;
      a_q        <= '0;
      b_q        <= '0;
      c_q        <= '0;
      s1_valid_q <= 1'b0;
      s1_idx_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      for (int m = 0; m < 4; m++) begin
        prod_q[m] <= '0;
      end
    end else begin
      done_q     <= 1'b0;
      s1_valid_q <= 1'b0;
      if (s1_valid_q) begin
        c_q[s1_idx_q] <= res;
      end
      case (state_q)
        StIdle: begin
          if (bus.start) begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            k_q     <= '0;
            busy_q  <= 1'b1;
            state_q <= StCompute;
          end
        end
        StCompute: begin
          prod_q     <= prod_d;
          s1_valid_q <= 1'b1;
          s1_idx_q   <= k_q;
          k_q        <= k_q + 4'd1;
          if (k_q == 4'd15) begin
            state_q <= StDrain;
          end
        end
        StDrain: state_q <= StDone;
        StDone: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.c    = c_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_mat_mult_engine.sv
// Self-checking bench for mat_mult_engine: vector table, scoreboard queue,
// plus protocol and asynchronous-reset sequences.
module tb_mat_mult_engine;
  typedef logic [511:0] mat_t;

  typedef struct {
    string name;
    mat_t  a;
    mat_t  b;
    mat_t  c;
  } vec_t;

  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_pass;
  mat_t sb_q[$];

  mat_mult_engine_if bus ();

  mat_mult_engine dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  task automatic check(input string what, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", what, act, exp);
  endtask

  // Reference: exact 66-bit dot products, floor shift, then wrap or clamp.
  function automatic mat_t model(input mat_t av, input mat_t bv);
    mat_t r;
    logic signed [65:0] acc;
    logic signed [31:0] x;
    logic signed [31:0] y;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        acc = '0;
        for (int m = 0; m < 4; m++) begin
          x   = av[(4*i+m)*32 +: 32];
          y   = bv[(4*m+j)*32 +: 32];
          acc = acc + 66'(x) * 66'(y);
        end
        acc = acc >>> 16;
`ifdef MAT_MULT_SATURATE_EN
        if (acc > 66'sd2147483647) acc = 66'sd2147483647;
        else if (acc < -66'sd2147483648) acc = -66'sd2147483648;
`endif
        r[(4*i+j)*32 +: 32] = acc[31:0];
      end
    end
    return r;
  endfunction

  task automatic wait_done(input string name, output int n, output bit busy_ok);
    n = 0;
    busy_ok = 1'b1;
    do begin
      @(posedge clk);
      #1;
      n++;
      if (!bus.done && !bus.busy) busy_ok = 1'b0;
    end while (!bus.done && n < 40);
  endtask

  // Starts an op (sampled at the next edge), then checks latency, busy and result.
  task automatic run_op(input string name, input mat_t av, input mat_t bv, input mat_t ev);
    int   n;
    bit   busy_ok;
    mat_t e;
    sb_q.push_back(ev);
    bus.a     = av;
    bus.b     = bv;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    check({name, " busy_after_start"}, 512'(bus.busy), 512'(1));
    check({name, " done_low_after_start"}, 512'(bus.done), 512'(0));
    wait_done(name, n, busy_ok);
    check({name, " latency"}, 512'(n), 512'(18));
    check({name, " busy_held"}, 512'(busy_ok), 512'(1));
    check({name, " busy_low_at_done"}, 512'(bus.busy), 512'(0));
    e = sb_q.pop_front();
    check({name, " result"}, bus.c, e);
  endtask

  initial begin
    vec_t vecs[9];
    mat_t ma;
    mat_t mb;
    mat_t mc;
    mat_t pa;
    mat_t pb;
    mat_t e;
    int   n;
    int   dones;
    logic [31:0] ovf;
    logic [31:0] novf;

    n_checks = 0;
    n_pass   = 0;

    // Identity A, B(r,c) = (4r+c+1) in Q16.16.
    ma = '0;
    mb = '0;
    for (int i = 0; i < 16; i++) begin
      if (i % 5 == 0) ma[i*32 +: 32] = 32'h0001_0000;
      mb[i*32 +: 32] = 32'(i + 1) << 16;
    end
    vecs[0] = '{"identity", ma, mb, mb};

    // 2.0*I times all -0.5 gives all -1.0.
    ma = '0;
    mb = '0;
    mc = '0;
    for (int i = 0; i < 16; i++) begin
      if (i % 5 == 0) ma[i*32 +: 32] = 32'h0002_0000;
      mb[i*32 +: 32] = 32'hFFFF_8000;
      mc[i*32 +: 32] = 32'hFFFF_0000;
    end
    vecs[1] = '{"signed_frac", ma, mb, mc};

    ma = '0;
    mb = '0;
    ma[31:0] = 32'h0000_0001;
    mb[31:0] = 32'h0000_8000;
    vecs[2] = '{"trunc_pos", ma, mb, 512'(0)};

    ma[31:0] = 32'hFFFF_FFFF;
    mc = '0;
    mc[31:0] = 32'hFFFF_FFFF;
    vecs[3] = '{"trunc_neg", ma, mb, mc};

`ifdef MAT_MULT_SATURATE_EN
    ovf  = 32'h7FFF_FFFF;
    novf = 32'h8000_0000;
`else
    ovf  = 32'h0004_0000;
    novf = 32'h0000_0000;
`endif
    for (int i = 0; i < 16; i++) begin
      ma[i*32 +: 32] = 32'h7FFF_0000;
      mc[i*32 +: 32] = ovf;
      mb[i*32 +: 32] = novf;
    end
    vecs[4] = '{"overflow_pos", ma, ma, mc};
    mc = mb;
    for (int i = 0; i < 16; i++) mb[i*32 +: 32] = 32'h8000_0000;
    vecs[5] = '{"overflow_neg", ma, mb, mc};

    for (int v = 6; v < 9; v++) begin
      for (int i = 0; i < 16; i++) begin
        if (v == 6) begin
          ma[i*32 +: 32] = $urandom();
          mb[i*32 +: 32] = $urandom();
        end else begin
          ma[i*32 +: 32] = $urandom_range(32'h0008_0000, 0) - 32'h0004_0000;
          mb[i*32 +: 32] = $urandom_range(32'h0008_0000, 0) - 32'h0004_0000;
        end
      end
      vecs[v] = '{$sformatf("random_%0d", v), ma, mb, model(ma, mb)};
    end

    reset_n   = 1'b0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    #1;
    check("reset busy", 512'(bus.busy), 512'(0));
    check("reset done", 512'(bus.done), 512'(0));
    check("reset c", bus.c, 512'(0));
    #12;
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Back-to-back: each op's start lands in the previous op's done cycle.
    for (int v = 0; v < 9; v++) begin
      run_op(vecs[v].name, vecs[v].a, vecs[v].b, vecs[v].c);
    end

    // Protocol: extra start pulses and operand changes while busy are ignored.
    pa = vecs[7].a;
    pb = vecs[7].b;
    sb_q.push_back(model(pa, pb));
    bus.a     = pa;
    bus.b     = pb;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a     = ~pa;
    bus.b     = vecs[6].b;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
      bus.start = (n == 4 || n == 9);
    end while (!bus.done && n < 40);
    bus.start = 1'b0;
    check("protocol latency", 512'(n), 512'(18));
    e = sb_q.pop_front();
    check("protocol result", bus.c, e);
    run_op("after_protocol", vecs[8].a, vecs[8].b, vecs[8].c);

    // Asynchronous reset mid-operation aborts and clears everything.
    bus.a     = vecs[0].a;
    bus.b     = vecs[0].b;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    check("abort partial c0", 512'(bus.c[31:0]), 512'(32'h0001_0000));
    #3;
    reset_n = 1'b0;
    #1;
    check("abort busy", 512'(bus.busy), 512'(0));
    check("abort done", 512'(bus.done), 512'(0));
    check("abort c", bus.c, 512'(0));
    @(posedge clk);
    #3;
    reset_n = 1'b1;
    dones = 0;
    repeat (25) begin
      @(posedge clk);
      #1;
      if (bus.done) dones++;
    end
    check("abort no_done", 512'(dones), 512'(0));
    check("abort idle_busy", 512'(bus.busy), 512'(0));
    run_op("after_reset", vecs[1].a, vecs[1].b, vecs[1].c);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
